omega_input_framer: RTL and testbench
=====================================

Name: omega_input_framer

Overview:
- Ingress stage directly upstream of the 8-port self-routing omega network.
- Accepts parallel packets on N_PORTS valid/ready ports: a destination address plus a payload.
- Buffers each port in a small FIFO and serialises packets bit-serially onto OutDat, which feeds the network's InDat.
- All ports transmit in lockstep slots, so routing bits reach each switch column aligned across ports.

Parameters:
- N_PORTS, 8, number of network input ports; power of two.
- ADDR_W, 3, destination address width; log2(N_PORTS).
- PAYLOAD_W, 8, payload bits per packet.
- FIFO_DEPTH, 4, packets buffered per port; power of two, at least 2.
- GAP, 1, idle zero bits at the end of each slot.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  N_PORTS  per-port packet valid.
- in_ready  out  N_PORTS  per-port FIFO not full.
- in_dest  in  N_PORTS*ADDR_W  port i destination at [i*ADDR_W +: ADDR_W].
- in_payload  in  N_PORTS*PAYLOAD_W  port i payload at [i*PAYLOAD_W +: PAYLOAD_W].
- OutDat  out  N_PORTS  bit-serial stream per port; connects to the network's InDat.
- frame_sync  out  1  high during slot cycle 0.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST_N is asynchronous and active-low.
- Slot timing:
  - SLOT_LEN = 1 + ADDR_W + PAYLOAD_W + GAP, which is 13 at defaults.
  - A slot counter slot_cnt runs 0..SLOT_LEN-1 and wraps to 0.
- Reset state:
  - slot_cnt = SLOT_LEN-1.
  - FIFOs empty; shift registers 0.
  - OutDat = 0, frame_sync = 0, in_ready = all 1.
  - Assertion clears everything immediately, mid-slot included; any partial packet is lost and is not resent.
- Handshake:
  - A push occurs on an edge with in_valid[i] & in_ready[i].
  - in_ready[i] = !full[i], computed from the registered count only. No bypass: a full FIFO shows ready low even in the cycle it pops.
  - in_dest and in_payload are ignored while in_valid is low.
- Load:
  - On the edge leaving slot_cnt == SLOT_LEN-1, each non-empty port pops its FIFO head into its shift register with a loaded flag of 1.
  - An empty port loads all zeros.
  - A push on that same edge into an empty FIFO is not sent in this slot; it goes in the next slot.
- Serial format, registered, during the cycle where slot_cnt == k:
  - k=0: start bit, 1 if loaded, else 0.
  - k=1..ADDR_W: dest bits, MSB first.
  - next PAYLOAD_W cycles: payload, MSB first.
  - last GAP cycles: 0.
  - An idle slot is all zeros.
- frame_sync is registered and high exactly during slot_cnt == 0, including the first slot after reset, which is idle.
- Latency: a packet accepted on edge E is sent in the first slot whose load edge is later than E. Its start bit appears 1..SLOT_LEN cycles after acceptance when the FIFO was empty.
- FIFO:
  - count is 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop with 0 < count < FIFO_DEPTH leaves count unchanged and preserves order.
- Ports are fully independent apart from the shared slot_cnt.
- The block does no contention handling; collisions are the network's concern.

Decomposition:
- Package omega_pkg holds:
  - constants N_PORTS, ADDR_W, PAYLOAD_W, GAP, SLOT_LEN;
  - a packet struct type {dest, payload};
  - the slot counter width $clog2(SLOT_LEN).
- Sub-module omega_port_serializer contains:
  - the FIFO, the shift register and the loaded flag;
  - inputs: load strobe and bit strobe from the top;
  - N_PORTS instances.
- The top holds slot_cnt, the frame_sync register and the bus slicing.

Test Plan:
- Reset behaviour: release RST_N, idle inputs.
  -> frame_sync pulses every 13 cycles, first pulse 1 cycle after release.
  -> OutDat stays 8'h00; in_ready stays 8'hFF.
- Single packet: port 0, dest 3'd5, payload 8'hA5, accepted before the load edge.
  -> OutDat[0] over the next slot is 1,1,0,1,1,0,1,0,0,1,0,1,0.
  -> Other ports stay 0.
- Full FIFO: push 5 packets back-to-back on port 3 with no load edge in between.
  -> in_ready[3] drops after the 4th push.
  -> The 5th is held, then accepted after the next pop.
  -> Slots carry packets in push order.
- Same-edge push into an empty FIFO: port 2, dest 3'd7, payload 8'hFF, pushed on the load edge.
  -> Current slot on port 2 is all 0.
  -> Next slot is 1,1,1,1, then 8 ones, then 0.
- All ports: all 8 ports push dest = port index, payload = 8'h10+i, simultaneously.
  -> All start bits high in the same cycle as frame_sync.
  -> Dest bits on OutDat[i] equal i, MSB first.
- Reset mid-slot: assert RST_N low at slot_cnt = 6 while port 1 is mid-packet with 2 queued.
  -> OutDat = 0 and FIFOs empty immediately.
  -> After release, the first slot is idle.

Source files
------------

// File: rtl/omega_pkg.sv
// Shared constants and types for the omega network ingress framer.
// Slot geometry and packet layout live here so every port agrees.
package omega_pkg;

  localparam int N_PORTS    = 8;
  localparam int ADDR_W     = 3;
  localparam int PAYLOAD_W  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP        = 1;

  localparam int SLOT_LEN = 1 + ADDR_W + PAYLOAD_W + GAP;
  localparam int CNT_W    = $clog2(SLOT_LEN);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]    dest;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  typedef logic [CNT_W-1:0] slot_t;

endpackage

// File: rtl/omega_port_serializer.sv
// One ingress port: packet FIFO feeding a slot-wide shift register.
// The top of the shift register is the loaded flag on slot cycle 0.
module omega_port_serializer
  import omega_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_stb,
  input  logic bit_stb,
  input  logic push_valid,
  input  pkt_t push_pkt,
  output logic push_ready,
  output logic serial_out
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  pkt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [SLOT_LEN-1:0] frame_sr;

  logic empty;
  logic push;
  logic pop;

  assign empty      = (count == '0);
  assign push_ready = (count != FULL_CNT);
  assign push       = push_valid & push_ready;
  assign pop        = load_stb & ~empty;
  assign serial_out = frame_sr[SLOT_LEN-1];

  // Packet storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_pkt;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Load a whole frame at slot start, then shift it out MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sr <= '0;
    end else if (load_stb) begin
      if (empty) frame_sr <= '0;
      else       frame_sr <= {1'b1, mem[rd_ptr], {GAP{1'b0}}};
    end else if (bit_stb) begin
      frame_sr <= frame_sr << 1;
    end
  end

endmodule

// File: rtl/omega_input_framer.sv
// Ingress framer: shared slot timing plus one serializer per port.
// All ports load on the same edge so routing bits stay column-aligned.
module omega_input_framer
  import omega_pkg::*;
(
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [N_PORTS-1:0]            in_valid,
  output logic [N_PORTS-1:0]            in_ready,
  input  logic [N_PORTS*ADDR_W-1:0]     in_dest,
  input  logic [N_PORTS*PAYLOAD_W-1:0]  in_payload,
  output logic [N_PORTS-1:0]            OutDat,
  output logic                          frame_sync
);

  localparam slot_t LAST = slot_t'(SLOT_LEN - 1);

  slot_t slot_cnt;
  logic  slot_end;

  assign slot_end = (slot_cnt == LAST);

  // Slot counter; reset parks it on the last cycle so the first edge loads.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_cnt   <= LAST;
      frame_sync <= 1'b0;
    end else begin
      slot_cnt   <= slot_end ? '0 : slot_cnt + 1'b1;
      frame_sync <= slot_end;
    end
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    pkt_t pkt;

    assign pkt.dest    = in_dest[i*ADDR_W +: ADDR_W];
    assign pkt.payload = in_payload[i*PAYLOAD_W +: PAYLOAD_W];

    omega_port_serializer u_ser (
      .clk        (CLK),
      .rst_n      (RST_N),
      .load_stb   (slot_end),
      .bit_stb    (~slot_end),
      .push_valid (in_valid[i]),
      .push_pkt   (pkt),
      .push_ready (in_ready[i]),
      .serial_out (OutDat[i])
    );
  end

endmodule

// File: tb/tb_omega_input_framer.sv
// Self-checking bench for omega_input_framer.
// Reference model: per-port packet queues and slot frames indexed by phase.
module tb_omega_input_framer;

  localparam int N     = 8;
  localparam int AW    = 3;
  localparam int PW    = 8;
  localparam int DEPTH = 4;
  localparam int SL    = 1 + AW + PW + 1;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N*AW-1:0] in_dest = '0;
  logic [N*PW-1:0] in_payload = '0;
  logic [N-1:0]    OutDat;
  logic            frame_sync;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  omega_input_framer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dest    (in_dest),
    .in_payload (in_payload),
    .OutDat     (OutDat),
    .frame_sync (frame_sync)
  );

  logic [AW+PW-1:0] q [N][$];
  logic [SL-1:0]    frame [N];
  int               phase;
  logic [N-1:0]     acc;

  function automatic logic [N-1:0] exp_out();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = frame[i][SL-1-phase];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (q[i].size() < DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      frame[i] = '0;
    end
    phase = SL - 1;
    acc   = '0;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic tick();
    logic [N-1:0] rdy;
    logic [AW+PW-1:0] p;
    @(posedge CLK);
    rdy = exp_ready();
    if (phase == SL - 1) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() > 0) begin
          p = q[i].pop_front();
          frame[i] = {1'b1, p, 1'b0};
        end else begin
          frame[i] = '0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      acc[i] = in_valid[i] & rdy[i];
      if (acc[i])
        q[i].push_back({in_dest[i*AW +: AW], in_payload[i*PW +: PW]});
    end
    phase = (phase + 1) % SL;
    #1;
  endtask

  task automatic set_pkt(int p, logic [AW-1:0] d, logic [PW-1:0] pl);
    in_valid[p]          = 1'b1;
    in_dest[p*AW +: AW]  = d;
    in_payload[p*PW +: PW] = pl;
  endtask

  task automatic idle_until(int ph);
    in_valid = '0;
    for (int n = 0; n < SL && phase != ph; n++) tick();
  endtask

  task automatic apply_reset();
    RST_N      = 1'b0;
    in_valid   = '0;
    in_dest    = '0;
    in_payload = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #3;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 3;
    if (OutDat !== 8'h00) begin
      errors++;
      $display("FAIL reset_out got %h exp 00", OutDat);
    end
    if (frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync got %b exp 0", frame_sync);
    end
    if (in_ready !== 8'hFF) begin
      errors++;
      $display("FAIL reset_ready got %h exp ff", in_ready);
    end
    tick();
    checks++;
    if (frame_sync !== 1'b1) begin
      errors++;
      $display("FAIL first_sync got %b exp 1", frame_sync);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      checks += 3;
      if (OutDat !== exp_out()) begin
        errors++;
        $display("FAIL idle_out got %h exp %h", OutDat, exp_out());
      end
      if (frame_sync !== (phase == 0)) begin
        errors++;
        $display("FAIL idle_sync got %b exp %b", frame_sync, phase == 0);
      end
      if (in_ready !== 8'hFF) begin
        errors++;
        $display("FAIL idle_ready got %h exp ff", in_ready);
      end
    end
  endtask

  task automatic test_single();
    logic [SL-1:0] bits;
    int cnt;
    bit started;
    bits = '0;
    cnt = 0;
    started = 0;
    idle_until(5);
    set_pkt(0, 3'd5, 8'hA5);
    tick();
    in_valid = '0;
    for (int c = 0; c < 30; c++) begin
      tick();
      checks += 3;
      if (OutDat !== exp_out()) begin
        errors++;
        $display("FAIL single_out got %h exp %h", OutDat, exp_out());
      end
      if (frame_sync !== (phase == 0)) begin
        errors++;
        $display("FAIL single_sync got %b exp %b", frame_sync, phase == 0);
      end
      if (in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL single_ready got %h exp %h", in_ready, exp_ready());
      end
      if (phase == 0) started = 1;
      if (started && cnt < SL) begin
        bits[SL-1-cnt] = OutDat[0];
        cnt++;
      end
    end
    checks++;
    if (bits !== 13'b1101101001010) begin
      errors++;
      $display("FAIL single_bits got %b exp 1101101001010", bits);
    end
  endtask

  task automatic test_full();
    int n;
    idle_until(0);
    for (int k = 0; k < 5; k++) begin
      set_pkt(3, AW'(k), 8'h30 + 8'(k));
      n = 0;
      do begin
        tick();
        n++;
        checks += 3;
        if (OutDat !== exp_out()) begin
          errors++;
          $display("FAIL full_out got %h exp %h", OutDat, exp_out());
        end
        if (frame_sync !== (phase == 0)) begin
          errors++;
          $display("FAIL full_sync got %b exp %b", frame_sync, phase == 0);
        end
        if (in_ready !== exp_ready()) begin
          errors++;
          $display("FAIL full_ready got %h exp %h", in_ready, exp_ready());
        end
      end while (!acc[3] && n < 30);
      if (!acc[3]) begin
        errors++;
        $display("FAIL full_timeout pkt %0d not accepted in %0d cycles", k, n);
      end
      if (k == 3) begin
        checks++;
        if (in_ready[3] !== 1'b0) begin
          errors++;
          $display("FAIL full_ready3 got %b exp 0", in_ready[3]);
        end
      end
    end
    in_valid = '0;
    for (int c = 0; c < 80; c++) begin
      tick();
      checks += 3;
      if (OutDat !== exp_out()) begin
        errors++;
        $display("FAIL drain_out got %h exp %h", OutDat, exp_out());
      end
      if (frame_sync !== (phase == 0)) begin
        errors++;
        $display("FAIL drain_sync got %b exp %b", frame_sync, phase == 0);
      end
      if (in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL drain_ready got %h exp %h", in_ready, exp_ready());
      end
    end
  endtask

  task automatic test_same_edge();
    logic [2*SL-1:0] bits;
    in_valid = '0;
    for (int n = 0; n < 120 && !queues_empty(); n++) tick();
    idle_until(SL - 1);
    set_pkt(2, 3'd7, 8'hFF);
    tick();
    in_valid = '0;
    for (int c = 0; c < 2*SL; c++) begin
      bits[2*SL-1-c] = OutDat[2];
      checks += 2;
      if (OutDat !== exp_out()) begin
        errors++;
        $display("FAIL same_out got %h exp %h", OutDat, exp_out());
      end
      if (frame_sync !== (phase == 0)) begin
        errors++;
        $display("FAIL same_sync got %b exp %b", frame_sync, phase == 0);
      end
      tick();
    end
    checks++;
    if (bits !== {13'b0, 13'b1111111111110}) begin
      errors++;
      $display("FAIL same_bits got %b exp %b", bits, {13'b0, 13'b1111111111110});
    end
  endtask

  task automatic test_all_ports();
    logic [AW-1:0] got [N];
    idle_until(3);
    for (int i = 0; i < N; i++) set_pkt(i, AW'(i), 8'h10 + 8'(i));
    tick();
    in_valid = '0;
    for (int n = 0; n < SL && phase != 0; n++) begin
      tick();
      checks++;
      if (OutDat !== exp_out()) begin
        errors++;
        $display("FAIL all_out got %h exp %h", OutDat, exp_out());
      end
    end
    checks += 2;
    if (OutDat !== 8'hFF) begin
      errors++;
      $display("FAIL all_start got %h exp ff", OutDat);
    end
    if (frame_sync !== 1'b1) begin
      errors++;
      $display("FAIL all_sync got %b exp 1", frame_sync);
    end
    for (int b = 0; b < AW; b++) begin
      tick();
      for (int i = 0; i < N; i++) got[i][AW-1-b] = OutDat[i];
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got[i] !== AW'(i)) begin
        errors++;
        $display("FAIL all_dest port %0d got %0d exp %0d", i, got[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [N-1:0] seen;
    in_valid = '0;
    for (int k = 0; k < 120 && !queues_empty(); k++) tick();
    idle_until(2);
    for (int k = 0; k < 3; k++) begin
      set_pkt(1, AW'(k + 1), 8'h60 + 8'(k));
      tick();
    end
    in_valid = '0;
    n = 0;
    while (!(phase == 6 && frame[1] != '0) && n < 30) begin
      tick();
      n++;
    end
    checks += 2;
    if (OutDat !== exp_out()) begin
      errors++;
      $display("FAIL mid_pre_out got %h exp %h", OutDat, exp_out());
    end
    if (in_ready !== exp_ready()) begin
      errors++;
      $display("FAIL mid_pre_ready got %h exp %h", in_ready, exp_ready());
    end
    #1;
    RST_N = 1'b0;
    #1;
    checks += 3;
    if (OutDat !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst_out got %h exp 00", OutDat);
    end
    if (in_ready !== 8'hFF) begin
      errors++;
      $display("FAIL mid_rst_ready got %h exp ff", in_ready);
    end
    if (frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_sync got %b exp 0", frame_sync);
    end
    apply_reset();
    seen = '0;
    for (int c = 0; c < 3*SL; c++) begin
      tick();
      seen |= OutDat;
      checks += 3;
      if (OutDat !== exp_out()) begin
        errors++;
        $display("FAIL post_rst_out got %h exp %h", OutDat, exp_out());
      end
      if (frame_sync !== (phase == 0)) begin
        errors++;
        $display("FAIL post_rst_sync got %b exp %b", frame_sync, phase == 0);
      end
      if (in_ready !== 8'hFF) begin
        errors++;
        $display("FAIL post_rst_ready got %h exp ff", in_ready);
      end
    end
    checks++;
    if (seen !== 8'h00) begin
      errors++;
      $display("FAIL post_rst_resend got %h exp 00", seen);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i] = ($urandom_range(0, 99) < 40);
        in_dest[i*AW +: AW] = AW'($urandom);
        in_payload[i*PW +: PW] = PW'($urandom);
      end
      tick();
      checks += 3;
      if (OutDat !== exp_out()) begin
        errors++;
        $display("FAIL rand_out got %h exp %h", OutDat, exp_out());
      end
      if (frame_sync !== (phase == 0)) begin
        errors++;
        $display("FAIL rand_sync got %b exp %b", frame_sync, phase == 0);
      end
      if (in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ready got %h exp %h", in_ready, exp_ready());
      end
    end
    in_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_full();
    test_same_edge();
    test_all_ports();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
